// File: rtl/rv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_stage
// Purpose  : Registered RV32I decode stage with a two-entry (main + skid)
//            output buffer, valid/ready on both sides and a flush that kills
//            every buffered entry.
// Revision : 1.0 - initial release
// ============================================================================
module rv_decode_stage #(
   parameter int XLEN   = 32,
   parameter int OPER_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OPER_W-1:0] out_oper,
   output logic [4:0]        out_rd,
   output logic [4:0]        out_rs1,
   output logic [4:0]        out_rs2,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_pc,
   output logic              out_we,
   output logic [1:0]        out_sl,
   output logic [2:0]        out_size,
   output logic              out_illegal
);

   typedef struct packed {
      logic [OPER_W-1:0] oper;
      logic [4:0]        rd;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      logic              we;
      logic [1:0]        sl;
      logic [2:0]        size;
      logic              illegal;
   } entry_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   state_e state_q;
   entry_t main_q;
   entry_t skid_q;
   entry_t dec_d;
   logic   in_ready_q;

   // Sign-extend a 32-bit immediate to the datapath width.
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] f_rd;
   logic [4:0] f_rs1;
   logic [4:0] f_rs2;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr;

   assign opcode  = in_inst[6:0];
   assign f3      = in_inst[14:12];
   assign f7      = in_inst[31:25];
   assign f_rd    = in_inst[11:7];
   assign f_rs1   = in_inst[19:15];
   assign f_rs2   = in_inst[24:20];
   assign imm_i   = sext32({{20{in_inst[31]}}, in_inst[31:20]});
   assign imm_s   = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
   assign imm_b   = sext32({{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0});
   assign imm_u   = sext32({in_inst[31:12], 12'b0});
   assign imm_j   = sext32({{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0});
   assign imm_csr = XLEN'(in_inst[31:20]);

   logic writes_rd;

   // Combinational decode of the incoming word; oper stays 0 for anything unrecognised.
   always_comb begin
      dec_d     = '0;
      dec_d.pc  = in_pc;
      writes_rd = 1'b0;
      unique case (opcode)
         7'b0110011: begin // R-type ALU
            dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.rs2 = f_rs2; writes_rd = 1'b1;
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'd0: dec_d.oper = OPER_W'(1);
                  3'd1: dec_d.oper = OPER_W'(3);
                  3'd2: dec_d.oper = OPER_W'(4);
                  3'd3: dec_d.oper = OPER_W'(5);
                  3'd4: dec_d.oper = OPER_W'(6);
                  3'd5: dec_d.oper = OPER_W'(7);
                  3'd6: dec_d.oper = OPER_W'(9);
                  default: dec_d.oper = OPER_W'(10);
               endcase
            end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
               dec_d.oper = OPER_W'(2);
            end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
               dec_d.oper = OPER_W'(8);
            end
         end
         7'b0010011: begin // I-type ALU; shifts also qualify funct7
            dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.imm = imm_i; writes_rd = 1'b1;
            case (f3)
               3'd0: dec_d.oper = OPER_W'(11);
               3'd2: dec_d.oper = OPER_W'(12);
               3'd3: dec_d.oper = OPER_W'(13);
               3'd4: dec_d.oper = OPER_W'(14);
               3'd6: dec_d.oper = OPER_W'(15);
               3'd7: dec_d.oper = OPER_W'(16);
               3'd1: if (f7 == 7'b0000000) dec_d.oper = OPER_W'(17);
               default: begin
                  if (f7 == 7'b0000000)      dec_d.oper = OPER_W'(18);
                  else if (f7 == 7'b0100000) dec_d.oper = OPER_W'(19);
               end
            endcase
         end
         7'b0000011: begin // loads
            dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.imm = imm_i; writes_rd = 1'b1;
            dec_d.sl = 2'b01; dec_d.size = f3;
            case (f3)
               3'd0: dec_d.oper = OPER_W'(20);
               3'd1: dec_d.oper = OPER_W'(21);
               3'd2: dec_d.oper = OPER_W'(22);
               3'd4: dec_d.oper = OPER_W'(23);
               3'd5: dec_d.oper = OPER_W'(24);
               default: ;
            endcase
         end
         7'b0100011: begin // stores
            dec_d.rs1 = f_rs1; dec_d.rs2 = f_rs2; dec_d.imm = imm_s;
            dec_d.sl = 2'b10; dec_d.size = f3;
            case (f3)
               3'd0: dec_d.oper = OPER_W'(25);
               3'd1: dec_d.oper = OPER_W'(26);
               3'd2: dec_d.oper = OPER_W'(27);
               default: ;
            endcase
         end
         7'b1100011: begin // branches
            dec_d.rs1 = f_rs1; dec_d.rs2 = f_rs2; dec_d.imm = imm_b;
            case (f3)
               3'd0: dec_d.oper = OPER_W'(28);
               3'd1: dec_d.oper = OPER_W'(29);
               3'd4: dec_d.oper = OPER_W'(30);
               3'd5: dec_d.oper = OPER_W'(31);
               3'd6: dec_d.oper = OPER_W'(32);
               3'd7: dec_d.oper = OPER_W'(33);
               default: ;
            endcase
         end
         7'b1101111: begin
            dec_d.rd = f_rd; dec_d.imm = imm_j; writes_rd = 1'b1; dec_d.oper = OPER_W'(34);
         end
         7'b1100111: begin
            dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.imm = imm_i; writes_rd = 1'b1;
            if (f3 == 3'd0) dec_d.oper = OPER_W'(35);
         end
         7'b0110111: begin
            dec_d.rd = f_rd; dec_d.imm = imm_u; writes_rd = 1'b1; dec_d.oper = OPER_W'(36);
         end
         7'b0010111: begin
            dec_d.rd = f_rd; dec_d.imm = imm_u; writes_rd = 1'b1; dec_d.oper = OPER_W'(37);
         end
         7'b0001111: begin // FENCE / FENCE.I keep their I-format fields but never write rd
            dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.imm = imm_i;
            if (f3 == 3'd0)      dec_d.oper = OPER_W'(38);
            else if (f3 == 3'd1) dec_d.oper = OPER_W'(39);
         end
         7'b1110011: begin // ECALL/EBREAK need all other fields zero; CSR ops use csr as imm
            if (f3 == 3'd0) begin
               if (in_inst[31:7] == 25'd0)                 dec_d.oper = OPER_W'(40);
               else if (in_inst[31:7] == 25'h0002000)      dec_d.oper = OPER_W'(41);
            end else if (f3 != 3'd4) begin
               dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.imm = imm_csr; writes_rd = 1'b1;
               dec_d.oper = OPER_W'({1'b0, f3[2]} * 3 + {1'b0, f3[1:0]} + 41);
            end
         end
         default: ;
      endcase
      if (dec_d.oper == '0) begin
         dec_d         = '0;
         dec_d.pc      = in_pc;
         dec_d.illegal = 1'b1;
      end else begin
         dec_d.we = writes_rd && (dec_d.rd != 5'd0);
      end
   end

   logic accept;
   logic pop;
   assign accept = in_valid && in_ready_q;
   assign pop    = (state_q != S_EMPTY) && out_ready;

   // Main/skid buffer control; flush empties it, reset clears every field.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
      end else if (flush) begin
         state_q    <= S_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         in_ready_q <= 1'b1;
         unique case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  main_q  <= dec_d;
                  state_q <= S_ONE;
               end
            end
            S_ONE: begin
               if (accept && !pop) begin
                  skid_q     <= dec_d;
                  state_q    <= S_FULL;
                  in_ready_q <= 1'b0;
               end else if (accept && pop) begin
                  main_q <= dec_d;
               end else if (pop) begin
                  state_q <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (pop) begin
                  main_q  <= skid_q;
                  state_q <= S_ONE;
               end else begin
                  in_ready_q <= 1'b0;
               end
            end
            default: state_q <= S_EMPTY;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != S_EMPTY);
   assign out_oper    = main_q.oper;
   assign out_rd      = main_q.rd;
   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_imm     = main_q.imm;
   assign out_pc      = main_q.pc;
   assign out_we      = main_q.we;
   assign out_sl      = main_q.sl;
   assign out_size    = main_q.size;
   assign out_illegal = main_q.illegal;

endmodule
`default_nettype wire
